// File: rtl/regfile_writeback_queue.sv
// Register-file writeback queue.
// Collects ALU and load results, keeps them in an in-order circular buffer,
// and drains one entry per cycle onto the register file's single write port.
// Entries still waiting in the buffer are visible to the three decode read
// ports through a youngest-match forwarding search.
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          ALUValid,
  input  logic [4:0]    ALUReg,
  input  logic [31:0]   ALUData,
  input  logic          MEMValid,
  input  logic [4:0]    MEMReg,
  input  logic [31:0]   MEMData,
  output logic          Stall,
  output logic [4:0]    WriteReg1,
  output logic [31:0]   WriteData1,
  output logic          Write1,
  input  logic [4:0]    RegA1,
  input  logic [4:0]    RegB1,
  input  logic [4:0]    RegC1,
  output logic          HitA1,
  output logic          HitB1,
  output logic          HitC1,
  output logic [31:0]   FwdA1,
  output logic [31:0]   FwdB1,
  output logic [31:0]   FwdC1,
  output logic [CW-1:0] Count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]    r_reg  [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_mem_q;
  logic          w_alu_q;
  logic          w_deq;
  logic [AW-1:0] w_alu_slot;
  logic [CW-1:0] w_enq_n;

  // Fewer than two free slots means a dual enqueue might not fit, so hold
  // the producers before that can happen.
  assign Stall   = (r_count > CW'(DEPTH - 2));

  // Writes to $zero are architecturally meaningless and are dropped here.
  assign w_mem_q = ~Stall & MEMValid & (MEMReg != 5'd0);
  assign w_alu_q = ~Stall & ALUValid & (ALUReg != 5'd0);

  // The load is the older instruction, so it takes the tail slot first and
  // the ALU result lands right behind it.
  assign w_alu_slot = w_mem_q ? (r_tail + AW'(1)) : r_tail;
  assign w_enq_n    = CW'(w_mem_q) + CW'(w_alu_q);

  // The head drains every cycle the queue is non-empty.
  assign w_deq      = (r_count != '0);
  assign Write1     = w_deq;
  assign WriteReg1  = w_deq ? r_reg[r_head]  : 5'd0;
  assign WriteData1 = w_deq ? r_data[r_head] : 32'd0;
  assign Count      = r_count;

  // Walk entries oldest to youngest so the last match (closest to tail) wins.
  function automatic logic [32:0] fwd_lookup(input logic [4:0] idx);
    logic [32:0]   v;
    logic [AW-1:0] slot;
    v = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = r_head + AW'(k);
      if ((CW'(k) < r_count) && (idx != 5'd0) && (r_reg[slot] == idx))
        v = {1'b1, r_data[slot]};
    end
    return v;
  endfunction

  // Forwarding search for the three decode read ports.
  always_comb begin
    {HitA1, FwdA1} = fwd_lookup(RegA1);
    {HitB1, FwdB1} = fwd_lookup(RegB1);
    {HitC1, FwdC1} = fwd_lookup(RegC1);
  end

  // Entry storage; contents are only meaningful inside the occupied window,
  // so no reset is needed here.
  always_ff @(posedge CLK) begin
    if (w_mem_q) begin
      r_reg[r_tail]  <= MEMReg;
      r_data[r_tail] <= MEMData;
    end
    if (w_alu_q) begin
      r_reg[w_alu_slot]  <= ALUReg;
      r_data[w_alu_slot] <= ALUData;
    end
  end

  // Pointer and occupancy bookkeeping; reset discards all queued entries.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_deq)
        r_head <= r_head + AW'(1);
      r_tail  <= r_tail + AW'(w_enq_n);
      r_count <= r_count + w_enq_n - CW'(w_deq);
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          ALUValid, MEMValid;
  logic [4:0]    ALUReg, MEMReg;
  logic [31:0]   ALUData, MEMData;
  logic          Stall, Write1;
  logic [4:0]    WriteReg1;
  logic [31:0]   WriteData1;
  logic [4:0]    RegA1, RegB1, RegC1;
  logic          HitA1, HitB1, HitC1;
  logic [31:0]   FwdA1, FwdB1, FwdC1;
  logic [CW-1:0] Count;

  regfile_writeback_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .CLK(CLK), .RESET(RESET),
    .ALUValid(ALUValid), .ALUReg(ALUReg), .ALUData(ALUData),
    .MEMValid(MEMValid), .MEMReg(MEMReg), .MEMData(MEMData),
    .Stall(Stall), .WriteReg1(WriteReg1), .WriteData1(WriteData1), .Write1(Write1),
    .RegA1(RegA1), .RegB1(RegB1), .RegC1(RegC1),
    .HitA1(HitA1), .HitB1(HitB1), .HitC1(HitC1),
    .FwdA1(FwdA1), .FwdB1(FwdB1), .FwdC1(FwdC1),
    .Count(Count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference lookup: youngest queued entry with a matching nonzero register.
  task automatic model_fwd(input logic [4:0] idx, output logic hit, output logic [31:0] data);
    hit  = 1'b0;
    data = 32'd0;
    if (idx != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].r == idx) begin
          hit  = 1'b1;
          data = q[i].d;
          break;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic        eh;
    logic [31:0] ed;
    chk($sformatf("%s.count", tag), 32'(Count), 32'(q.size()));
    chk($sformatf("%s.stall", tag), 32'(Stall), 32'(q.size() > DEPTH - 2));
    chk($sformatf("%s.write1", tag), 32'(Write1), 32'(q.size() != 0));
    chk($sformatf("%s.wreg", tag), 32'(WriteReg1), (q.size() != 0) ? 32'(q[0].r) : 32'd0);
    chk($sformatf("%s.wdata", tag), WriteData1, (q.size() != 0) ? q[0].d : 32'd0);
    model_fwd(RegA1, eh, ed);
    chk($sformatf("%s.hitA", tag), 32'(HitA1), 32'(eh));
    chk($sformatf("%s.fwdA", tag), FwdA1, ed);
    model_fwd(RegB1, eh, ed);
    chk($sformatf("%s.hitB", tag), 32'(HitB1), 32'(eh));
    chk($sformatf("%s.fwdB", tag), FwdB1, ed);
    model_fwd(RegC1, eh, ed);
    chk($sformatf("%s.hitC", tag), 32'(HitC1), 32'(eh));
    chk($sformatf("%s.fwdC", tag), FwdC1, ed);
  endtask

  // Model of one rising edge: reset clears; otherwise pop head, then accept
  // MEM before ALU unless the queue was nearly full.
  task automatic model_edge();
    logic st;
    st = (q.size() > DEPTH - 2);
    if (RESET) begin
      q.delete();
    end else begin
      if (q.size() != 0) void'(q.pop_front());
      if (!st) begin
        if (MEMValid && MEMReg != 5'd0) q.push_back(ent_t'{r: MEMReg, d: MEMData});
        if (ALUValid && ALUReg != 5'd0) q.push_back(ent_t'{r: ALUReg, d: ALUData});
      end
    end
  endtask

  task automatic step(input string tag);
    #1;
    check_all(tag);
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    RESET    = 1'b0;
    ALUValid = 1'b0; ALUReg = 5'd0; ALUData = 32'd0;
    MEMValid = 1'b0; MEMReg = 5'd0; MEMData = 32'd0;
  endtask

  initial begin
    idle_inputs();
    RegA1 = 5'd0; RegB1 = 5'd0; RegC1 = 5'd0;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    // Reset then idle.
    RegA1 = 5'd5;
    #1;
    chk("rst.count", 32'(Count), 32'd0);
    chk("rst.write1", 32'(Write1), 32'd0);
    chk("rst.stall", 32'(Stall), 32'd0);
    chk("rst.hitA", 32'(HitA1), 32'd0);
    step("rst_idle");

    // Single ALU result, one-cycle latency to the write port.
    ALUValid = 1'b1; ALUReg = 5'd3; ALUData = 32'hDEADBEEF;
    step("alu_in");
    idle_inputs();
    RegA1 = 5'd3;
    #1;
    chk("alu.write1", 32'(Write1), 32'd1);
    chk("alu.wreg", 32'(WriteReg1), 32'd3);
    chk("alu.wdata", WriteData1, 32'hDEADBEEF);
    chk("alu.hitA", 32'(HitA1), 32'd1);
    chk("alu.fwdA", FwdA1, 32'hDEADBEEF);
    step("alu_out");
    #1;
    chk("alu.drained", 32'(Write1), 32'd0);
    step("alu_empty");

    // Same-cycle MEM and ALU to the same register: MEM drains first, ALU forwards.
    MEMValid = 1'b1; MEMReg = 5'd7; MEMData = 32'h11;
    ALUValid = 1'b1; ALUReg = 5'd7; ALUData = 32'h22;
    step("dual_in");
    idle_inputs();
    RegB1 = 5'd7;
    #1;
    chk("dual.wdata0", WriteData1, 32'h11);
    chk("dual.hitB", 32'(HitB1), 32'd1);
    chk("dual.fwdB", FwdB1, 32'h22);
    step("dual_out0");
    #1;
    chk("dual.wdata1", WriteData1, 32'h22);
    step("dual_out1");

    // Write to $zero is dropped.
    ALUValid = 1'b1; ALUReg = 5'd0; ALUData = 32'h55;
    step("zero_in");
    idle_inputs();
    #1;
    chk("zero.count", 32'(Count), 32'd0);
    chk("zero.write1", 32'(Write1), 32'd0);
    step("zero_after");

    // Both producers every cycle: stall engages and entries drain across wrap.
    for (int i = 0; i < 10; i++) begin
      MEMValid = 1'b1; MEMReg = 5'(1 + 2 * (i % 15)); MEMData = 32'h1000 + 32'(i);
      ALUValid = 1'b1; ALUReg = 5'(2 + 2 * (i % 15)); ALUData = 32'h2000 + 32'(i);
      RegA1 = MEMReg; RegB1 = 5'(2 + 2 * ((i + 14) % 15)); RegC1 = 5'd1;
      step($sformatf("full%0d", i));
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) step($sformatf("drain%0d", i));

    // Reset discards queued entries even with a producer active.
    MEMValid = 1'b1; MEMReg = 5'd9;  MEMData = 32'hA9;
    ALUValid = 1'b1; ALUReg = 5'd10; ALUData = 32'hAA;
    step("load0");
    MEMReg = 5'd11; MEMData = 32'hAB;
    ALUReg = 5'd12; ALUData = 32'hAC;
    step("load1");
    idle_inputs();
    RESET = 1'b1; ALUValid = 1'b1; ALUReg = 5'd13; ALUData = 32'hAD;
    step("rst_mid");
    idle_inputs();
    RegA1 = 5'd12; RegB1 = 5'd11; RegC1 = 5'd13;
    #1;
    chk("rstq.count", 32'(Count), 32'd0);
    chk("rstq.write1", 32'(Write1), 32'd0);
    chk("rstq.hitA", 32'(HitA1), 32'd0);
    for (int i = 0; i < 3; i++) step($sformatf("rstq%0d", i));

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      RESET    = ($urandom_range(0, 59) == 0);
      MEMValid = ($urandom_range(0, 9) < 6);
      MEMReg   = 5'($urandom_range(0, 7));
      MEMData  = $urandom;
      ALUValid = ($urandom_range(0, 9) < 6);
      ALUReg   = 5'($urandom_range(0, 7));
      ALUData  = $urandom;
      RegA1    = 5'($urandom_range(0, 7));
      RegB1    = 5'($urandom_range(0, 7));
      RegC1    = 5'($urandom_range(0, 7));
      step($sformatf("rnd%0d", i));
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) step($sformatf("final%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Producer side of the register file write port: collects writeback results from the ALU and memory stages.
- Buffers them in a small in-order FIFO and drains exactly one per cycle onto the register file's single write port (WriteReg1/WriteData1/Write1).
- Provides forwarding lookups for the three decode read ports, so values still queued are visible before they reach the register file.

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.
- CW, 3, width of Count; must hold 0..DEPTH ($clog2(DEPTH+1)).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- ALUValid  in  1  ALU result present this cycle.
- ALUReg  in  5  ALU destination register.
- ALUData  in  32  ALU result.
- MEMValid  in  1  load result present this cycle.
- MEMReg  in  5  load destination register.
- MEMData  in  32  load result.
- Stall  out  1  producers must hold; inputs ignored while high.
- WriteReg1  out  5  register file write index.
- WriteData1  out  32  register file write data.
- Write1  out  1  register file write enable.
- RegA1  in  5  forwarding lookup index A.
- RegB1  in  5  forwarding lookup index B.
- RegC1  in  5  forwarding lookup index C.
- HitA1  out  1  lookup A matches a queued entry.
- HitB1  out  1  lookup B matches a queued entry.
- HitC1  out  1  lookup C matches a queued entry.
- FwdA1  out  32  forwarded data for A; 0 when no hit.
- FwdB1  out  32  forwarded data for B; 0 when no hit.
- FwdC1  out  32  forwarded data for C; 0 when no hit.
- Count  out  CW  current number of queued entries.

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries {reg[4:0], data[31:0]}.
  - Head/tail pointers wrap modulo DEPTH.
  - Count register tracks occupancy.
- Reset (RESET=1 at a rising edge):
  - Count=0, head=tail=0.
  - Outputs: Write1=0, Stall=0, Hit*=0, Fwd*=0, Count=0.
  - Overrides any same-cycle enqueue or dequeue; queued entries are discarded and never written.
- Stall:
  - Combinational: Stall = (Count > DEPTH-2), i.e. fewer than 2 free slots.
  - While Stall=1, ALUValid and MEMValid are ignored and nothing is enqueued.
- Enqueue (Stall=0):
  - An input qualifies when Valid=1 and Reg != 0; writes to $zero are dropped silently.
  - Order within a cycle: MEM entry first (older instruction), then ALU entry.
  - 0, 1 or 2 entries are enqueued per cycle.
- Dequeue:
  - Write1 = (Count != 0), combinational.
  - WriteReg1/WriteData1 = head entry; both are 0 when empty.
  - The head pops at every rising edge where Write1=1. The register file captures the entry on that same edge.
- Latency:
  - An input presented in cycle N to an empty queue appears on the write port in cycle N+1.
  - It is committed to the register file at the end of cycle N+1.
- Occupancy update: Count_next = Count + enq_n - deq, where enq_n is 0..2 and deq is 0..1. Simultaneous enqueue and dequeue are legal, and Count never exceeds DEPTH.
- Forwarding (combinational):
  - Each lookup compares against all valid entries, including the head being written this cycle.
  - On multiple matches, the youngest entry (closest to tail) wins.
  - Lookup of register 0 never hits.
  - Current-cycle inputs are not searched.
- Pointer wrap: tail and head wrap from DEPTH-1 to 0 with no bubble; ordering is preserved across the wrap.

Test Plan:
- Reset then idle -> Count=0, Write1=0, Stall=0, HitA1=0 for RegA1=5.
- ALUValid=1, ALUReg=3, ALUData=0xDEADBEEF in cycle 0 -> cycle 1: Write1=1, WriteReg1=3, WriteData1=0xDEADBEEF, HitA1=1 with FwdA1=0xDEADBEEF for RegA1=3; cycle 2: Write1=0.
- Same cycle MEM(reg 7, 0x11) and ALU(reg 7, 0x22) ->
  - Next cycle: write port shows 0x11 and FwdB1=0x22 for RegB1=7.
  - Following cycle: write port shows 0x22.
- ALUValid=1, ALUReg=0, data 0x55 -> nothing enqueued, Count stays 0, Write1 stays 0.
- Both producers valid every cycle with distinct regs, DEPTH=4 ->
  - Stall rises once Count reaches 3.
  - Inputs presented during Stall are absent from the write-port sequence.
  - All accepted entries drain in order across pointer wrap.
- Load 3 entries, assert RESET for one cycle with ALUValid=1 -> next cycle Count=0, Write1=0, no Hit; the discarded entries never appear on the write port.
